// File: rtl/tia_phase_gen.sv
// Two-phase non-overlapping strobe generator with a 6-bit polynomial
// horizontal-counter reference. Both strobes are derived from a single master
// clock divided by PERIOD; the LFSR steps once per phase cycle on the edge
// where s2 falls, and reloads to zero from WRAP_STATE with a one-clock wrap
// pulse.
module tia_phase_gen #(
    parameter int unsigned PERIOD     = 4,
    parameter int unsigned S1_WIDTH   = 1,
    parameter int unsigned S2_OFFSET  = 2,
    parameter int unsigned S2_WIDTH   = 1,
    parameter logic [5:0]  WRAP_STATE = 6'b101101
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       sync_rst,
    output logic       s1,
    output logic       s2,
    output logic [3:0] phase,
    output logic [5:0] count,
    output logic       wrap
);

    // Parameter legality: PERIOD fits the 4-bit phase index, both strobes are
    // at least one clock wide, and there is a dead clock between s1 falling
    // and s2 rising as well as between s2 falling and the next s1.
    if (PERIOD < 4 || PERIOD > 16) begin : g_bad_period
        $error("tia_phase_gen: PERIOD must be in 4..16");
    end
    if (S1_WIDTH < 1 || S2_WIDTH < 1) begin : g_bad_width
        $error("tia_phase_gen: S1_WIDTH and S2_WIDTH must be at least 1");
    end
    if (S2_OFFSET < S1_WIDTH + 1) begin : g_bad_offset
        $error("tia_phase_gen: S2_OFFSET must leave a dead clock after s1");
    end
    if (S2_OFFSET + S2_WIDTH > PERIOD - 1) begin : g_bad_tail
        $error("tia_phase_gen: s2 must end at least one clock before the cycle wraps");
    end

    // Phase index constants. Comparisons against the new phase are done in
    // 5 bits so that S2_OFFSET+S2_WIDTH == 16 cannot alias to zero.
    localparam logic [3:0] PH_LAST = 4'(PERIOD - 1);
    localparam logic [3:0] S2_LAST = 4'(S2_OFFSET + S2_WIDTH - 1);
    localparam logic [4:0] S1_END  = 5'(S1_WIDTH);
    localparam logic [4:0] S2_BEG  = 5'(S2_OFFSET);
    localparam logic [4:0] S2_END  = 5'(S2_OFFSET + S2_WIDTH);

    // One step of the polynomial counter: XNOR of the two top bits shifted in.
    function automatic logic [5:0] lfsr_step(input logic [5:0] cur);
        return {cur[4:0], ~(cur[5] ^ cur[4])};
    endfunction

    logic [3:0] phase_q, phase_d;
    logic       s1_q, s1_d;
    logic       s2_q, s2_d;
    logic [5:0] count_q, count_d;
    logic       wrap_q, wrap_d;

    logic [3:0] phase_inc;
    logic [4:0] phase_inc_w;
    logic       lfsr_adv;

    // Phase successor and the strobe decode of that successor.
    always_comb begin
        phase_inc   = (phase_q == PH_LAST) ? 4'd0 : phase_q + 4'd1;
        phase_inc_w = {1'b0, phase_inc};
        lfsr_adv    = (phase_q == S2_LAST);
    end

    // Next-state selection: sync restart beats enable; a disabled edge holds
    // the phase and counter but forces both strobes and wrap low.
    always_comb begin
        phase_d = phase_q;
        s1_d    = 1'b0;
        s2_d    = 1'b0;
        count_d = count_q;
        wrap_d  = 1'b0;
        if (sync_rst) begin
            phase_d = PH_LAST;
            count_d = 6'd0;
        end else if (en) begin
            phase_d = phase_inc;
            s1_d    = (phase_inc_w < S1_END);
            s2_d    = (phase_inc_w >= S2_BEG) && (phase_inc_w < S2_END);
            if (lfsr_adv) begin
                if (count_q == WRAP_STATE) begin
                    count_d = 6'd0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = lfsr_step(count_q);
                end
            end
        end
    end

    // State registers; reset parks the phase on the last index so the first
    // enabled edge lands on phase 0 and raises s1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= PH_LAST;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            count_q <= 6'd0;
            wrap_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign s1    = s1_q;
    assign s2    = s2_q;
    assign phase = phase_q;
    assign count = count_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_tia_phase_gen.sv
// Bench for tia_phase_gen: three builds (default, wide PERIOD=8 strobes,
// short WRAP_STATE=3) share the stimulus; a behavioural model per build is
// checked every cycle, and directed scenarios pin literal values.
module tb_tia_phase_gen;

    localparam int NB = 3;
    localparam int PER [NB] = '{4, 8, 4};
    localparam int S1W [NB] = '{1, 2, 1};
    localparam int S2O [NB] = '{2, 4, 2};
    localparam int S2W [NB] = '{1, 2, 1};
    localparam int WST [NB] = '{45, 45, 3};

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic en = 1'b0;
    logic sync_rst = 1'b0;

    logic       s1_v  [NB];
    logic       s2_v  [NB];
    logic [3:0] ph_v  [NB];
    logic [5:0] cnt_v [NB];
    logic       wr_v  [NB];

    int n_tests = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    // behavioural model state
    int m_ph  [NB];
    int m_cnt [NB];
    bit m_s1  [NB];
    bit m_s2  [NB];
    bit m_wr  [NB];
    bit p_s1  [NB];
    bit p_s2  [NB];

    // literal expectations for the default build after edges 1..16 from reset
    int e_s1  [16] = '{1,0,0,0, 1,0,0,0, 1,0,0,0, 1,0,0,0};
    int e_s2  [16] = '{0,0,1,0, 0,0,1,0, 0,0,1,0, 0,0,1,0};
    int e_cnt [16] = '{0,0,0,1, 1,1,1,3, 3,3,3,7, 7,7,7,15};
    // WRAP_STATE=3 build: 0,1,3 then reload to 0 with a wrap pulse
    int e_wc  [16] = '{0,0,0,1, 1,1,1,3, 3,3,3,0, 0,0,0,1};
    int e_ww  [16] = '{0,0,0,0, 0,0,0,0, 0,0,0,1, 0,0,0,0};

    tia_phase_gen #(.PERIOD(4), .S1_WIDTH(1), .S2_OFFSET(2), .S2_WIDTH(1),
                    .WRAP_STATE(6'b101101)) u_def (
        .clk(clk), .reset(reset), .en(en), .sync_rst(sync_rst),
        .s1(s1_v[0]), .s2(s2_v[0]), .phase(ph_v[0]), .count(cnt_v[0]), .wrap(wr_v[0]));

    tia_phase_gen #(.PERIOD(8), .S1_WIDTH(2), .S2_OFFSET(4), .S2_WIDTH(2),
                    .WRAP_STATE(6'b101101)) u_wide (
        .clk(clk), .reset(reset), .en(en), .sync_rst(sync_rst),
        .s1(s1_v[1]), .s2(s2_v[1]), .phase(ph_v[1]), .count(cnt_v[1]), .wrap(wr_v[1]));

    tia_phase_gen #(.PERIOD(4), .S1_WIDTH(1), .S2_OFFSET(2), .S2_WIDTH(1),
                    .WRAP_STATE(6'b000011)) u_wrap (
        .clk(clk), .reset(reset), .en(en), .sync_rst(sync_rst),
        .s1(s1_v[2]), .s2(s2_v[2]), .phase(ph_v[2]), .count(cnt_v[2]), .wrap(wr_v[2]));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lfsr_next(input int c);
        int b5, b4;
        b5 = (c / 32) % 2;
        b4 = (c / 16) % 2;
        return ((c * 2) % 64) + ((b5 == b4) ? 1 : 0);
    endfunction

    // Model: position within the phase cycle, strobe windows, counter step
    // when leaving the last s2 slot.
    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < NB; i++) begin
            if (reset || sync_rst) begin
                m_ph[i]  = PER[i] - 1;
                m_cnt[i] = 0;
                m_s1[i]  = 0;
                m_s2[i]  = 0;
                m_wr[i]  = 0;
            end else if (en) begin
                bit leaving_s2;
                leaving_s2 = (m_ph[i] == S2O[i] + S2W[i] - 1);
                m_ph[i] = (m_ph[i] + 1) % PER[i];
                m_s1[i] = (m_ph[i] < S1W[i]);
                m_s2[i] = (m_ph[i] >= S2O[i]) && (m_ph[i] < S2O[i] + S2W[i]);
                m_wr[i] = 0;
                if (leaving_s2) begin
                    if (m_cnt[i] == WST[i]) begin
                        m_cnt[i] = 0;
                        m_wr[i]  = 1;
                    end else begin
                        m_cnt[i] = lfsr_next(m_cnt[i]);
                    end
                end
            end else begin
                m_s1[i] = 0;
                m_s2[i] = 0;
                m_wr[i] = 0;
            end
        end
    end

    // Per-cycle comparison against the model plus overlap / dead-clock checks.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < NB; i++) begin
                chk($sformatf("b%0d_s1", i), int'(s1_v[i]), int'(m_s1[i]));
                chk($sformatf("b%0d_s2", i), int'(s2_v[i]), int'(m_s2[i]));
                chk($sformatf("b%0d_phase", i), int'(ph_v[i]), m_ph[i]);
                chk($sformatf("b%0d_count", i), int'(cnt_v[i]), m_cnt[i]);
                chk($sformatf("b%0d_wrap", i), int'(wr_v[i]), int'(m_wr[i]));
                chk($sformatf("b%0d_overlap", i), int'(s1_v[i] & s2_v[i]), 0);
                chk($sformatf("b%0d_deadclk", i),
                    int'((s1_v[i] & p_s2[i]) | (s2_v[i] & p_s1[i])), 0);
                p_s1[i] = s1_v[i];
                p_s2[i] = s2_v[i];
            end
        end
    end

    task automatic edge_n(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
        end
        #1;
    endtask

    // 16 enabled edges from a reset/restart state with literal expectations.
    task automatic run_basic(input string tag);
        for (int k = 0; k < 16; k++) begin
            edge_n(1);
            chk($sformatf("%s_s1_e%0d", tag, k + 1), int'(s1_v[0]), e_s1[k]);
            chk($sformatf("%s_s2_e%0d", tag, k + 1), int'(s2_v[0]), e_s2[k]);
            chk($sformatf("%s_cnt_e%0d", tag, k + 1), int'(cnt_v[0]), e_cnt[k]);
            chk($sformatf("%s_wcnt_e%0d", tag, k + 1), int'(cnt_v[2]), e_wc[k]);
            chk($sformatf("%s_wrap_e%0d", tag, k + 1), int'(wr_v[2]), e_ww[k]);
            if (k == 11) begin
                chk($sformatf("%s_model_cnt12", tag), m_cnt[0], 7);
                chk($sformatf("%s_model_wrap12", tag), int'(m_wr[2]), 1);
            end
        end
    endtask

    initial begin
        bit found;
        reset = 1'b0;
        #1 reset = 1'b1;
        chk_on = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_phase", int'(ph_v[0]), 3);
        chk("rst_phase_wide", int'(ph_v[1]), 7);
        chk("rst_s1", int'(s1_v[0]), 0);
        chk("rst_s2", int'(s2_v[0]), 0);
        chk("rst_count", int'(cnt_v[0]), 0);
        chk("rst_wrap", int'(wr_v[0]), 0);
        reset = 1'b0;
        en = 1'b1;

        // free-running default sequence and wrap build
        run_basic("basic");

        // freeze while s2 is high, then resume
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            @(negedge clk);
            if (ph_v[0] == 4'd2) found = 1'b1;
        end
        chk("find_phase2_timeout", int'(found), 1);
        chk("pre_freeze_s2", int'(s2_v[0]), 1);
        chk("pre_freeze_cnt", int'(cnt_v[0]), 15);
        en = 1'b0;
        edge_n(1);
        chk("frz_s2", int'(s2_v[0]), 0);
        chk("frz_phase", int'(ph_v[0]), 2);
        chk("frz_cnt", int'(cnt_v[0]), 15);
        edge_n(1);
        chk("frz2_phase", int'(ph_v[0]), 2);
        chk("frz2_s2", int'(s2_v[0]), 0);
        @(negedge clk);
        en = 1'b1;
        edge_n(1);
        chk("resume_phase", int'(ph_v[0]), 3);
        chk("resume_cnt", int'(cnt_v[0]), 31);
        chk("resume_s2", int'(s2_v[0]), 0);

        // sync_rst together with en: restart wins, no strobe
        @(negedge clk);
        sync_rst = 1'b1;
        edge_n(1);
        chk("srst_en_s1", int'(s1_v[0]), 0);
        chk("srst_en_phase", int'(ph_v[0]), 3);
        chk("srst_en_cnt", int'(cnt_v[0]), 0);
        @(negedge clk);
        sync_rst = 1'b0;
        edge_n(8);
        chk("srst_cnt_e8", int'(cnt_v[0]), 3);
        edge_n(3);
        chk("srst_pre_phase", int'(ph_v[0]), 2);
        chk("srst_pre_cnt", int'(cnt_v[0]), 3);
        @(negedge clk);
        sync_rst = 1'b1;
        edge_n(1);
        chk("srst_phase", int'(ph_v[0]), 3);
        chk("srst_cnt", int'(cnt_v[0]), 0);
        chk("srst_s1", int'(s1_v[0]), 0);
        chk("srst_s2", int'(s2_v[0]), 0);
        chk("srst_wrap", int'(wr_v[2]), 0);
        @(negedge clk);
        sync_rst = 1'b0;
        edge_n(1);
        chk("srst_next_s1", int'(s1_v[0]), 1);
        chk("srst_next_phase", int'(ph_v[0]), 0);
        edge_n(4);
        chk("pre_arst_s1", int'(s1_v[0]), 1);
        chk("pre_arst_cnt", int'(cnt_v[0]), 1);

        // asynchronous reset between edges while s1 is high
        #1 reset = 1'b1;
        #1;
        chk("arst_s1", int'(s1_v[0]), 0);
        chk("arst_s2", int'(s2_v[0]), 0);
        chk("arst_cnt", int'(cnt_v[0]), 0);
        chk("arst_wcnt", int'(cnt_v[2]), 0);
        chk("arst_wrap", int'(wr_v[2]), 0);
        chk("arst_phase", int'(ph_v[0]), 3);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_basic("post_arst");

        // random enable toggling with occasional restarts
        for (int k = 0; k < 10000; k++) begin
            @(negedge clk);
            en = ($urandom_range(0, 3) != 0);
            sync_rst = ($urandom_range(0, 63) == 0);
        end
        @(negedge clk);
        en = 1'b0;
        sync_rst = 1'b0;
        @(negedge clk);
        chk_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tia_phase_gen.md
Name: tia_phase_gen

Overview:
- Generates the non-overlapping two-phase strobes (s1, s2) that clock chains of D1 delay stages. It is the driving end of the s1/s2 interface those stages consume.
- Derives both phases from the single master clock by a programmable divide, default divide-by-4 as in the TIA horizontal clock section.
- Also steps a 6-bit polynomial (LFSR) counter once per phase cycle, latching on the s2 phase, and flags wrap-around. This serves as the horizontal-counter reference for D1 chains.

Parameters:
- PERIOD, 4, master clocks per phase cycle (legal range 4..16).
- S1_WIDTH, 1, clocks s1 is high, starting at phase 0.
- S2_OFFSET, 2, phase index at which s2 rises.
- S2_WIDTH, 1, clocks s2 is high.
- WRAP_STATE, 6'b101101, LFSR value that forces reload to zero.

Ports:
- clk  input  1  master clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  advance enable; low freezes the phase sequence.
- sync_rst  input  1  synchronous restart of phase and LFSR (TIA RES-style).
- s1  output  1  phase-1 strobe, registered.
- s2  output  1  phase-2 strobe, registered.
- phase  output  4  current phase index 0..PERIOD-1.
- count  output  6  LFSR counter value.
- wrap  output  1  one-clock pulse after the LFSR reloads from WRAP_STATE.

Behaviour:
- Elaboration must fail unless all of the following hold:
  - S1_WIDTH >= 1 and S2_WIDTH >= 1
  - S2_OFFSET >= S1_WIDTH + 1
  - S2_OFFSET + S2_WIDTH <= PERIOD - 1
  - Together these guarantee at least one dead clock between phases in both directions.
- Async reset: phase = PERIOD-1, s1 = 0, s2 = 0, count = 0, wrap = 0.
- Each clk edge, priority order:
  1. sync_rst high: phase <= PERIOD-1; s1, s2, count, wrap <= 0.
  2. en high: phase <= (phase+1) mod PERIOD.
     - s1 <= (new phase < S1_WIDTH).
     - s2 <= (S2_OFFSET <= new phase < S2_OFFSET+S2_WIDTH).
  3. en low: phase holds; s1, s2 <= 0 at that edge; count holds; wrap <= 0.
- s1 and s2 come directly from flops: no glitches, never both high, no combinational path from inputs.
- First enabled edge after reset or sync_rst raises s1, so latency is 1 clock.
- Freeze/resume: when en returns high, the sequence continues from the held phase. A strobe interrupted by en low is not re-extended.
- LFSR advance:
  - Occurs only on an enabled edge where the pre-edge phase == S2_OFFSET+S2_WIDTH-1, i.e. the edge on which s2 falls.
  - Feedback: fb = ~(count[5] ^ count[4]); next = {count[4:0], fb}.
  - If the pre-edge count == WRAP_STATE, then count <= 0 instead, and wrap <= 1 for exactly the following clock.
- wrap is 0 on every other edge.
- Reset asserted mid-cycle: outputs go to reset values immediately, independent of clk.
- sync_rst together with en: sync_rst wins. No strobe is emitted on that edge.
- count and phase are plain registered values, stable for the whole clock.

Test Plan:
- Defaults, release reset with en=1 → s1 high after edges 1, 5, 9; s2 high after edges 3, 7, 11; both low otherwise; count = 000001 after edge 4, 000011 after edge 8, 000111 after edge 12.
- Overlap check: random en toggling for 10k clocks with defaults, plus a PERIOD=8, S1_WIDTH=2, S2_OFFSET=4, S2_WIDTH=2 build → s1&s2 never high. In every run of consecutive enabled clocks, each s1 pulse and s2 pulse is separated by at least one dead clock.
- en dropped during an s2-high clock → s2 low next edge, phase frozen at 2, count unchanged. On resume, the next enabled edge gives phase 3 and count advances.
- WRAP_STATE=6'b000011 → count sequence 0, 1, 3, 0. wrap is high for exactly one clock after the 000011→000000 edge, and the sequence then repeats.
- sync_rst pulsed while phase=2, count=000011 → phase=PERIOD-1 (3 with defaults), count=0, s1/s2/wrap low. The next enabled edge gives s1=1.
- Async reset asserted between clock edges while s1 high → s1, s2, count, wrap go to 0 without a clk edge. After release, behaviour matches the first scenario.
